// File: rtl/event_arbiter.sv
// Four-channel asynchronous event capture with per-channel timestamping and a
// round-robin output record stage. Define EVENT_ARBITER_BOTH_EDGES_EN to also capture falling edges.
module event_arbiter #(
    parameter int unsigned TS_W        = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      ev_in,
    input  logic            enable,
    input  logic            ready,
    input  logic            clr_ovf,
    output logic            valid,
    output logic [1:0]      ch_out,
    output logic [TS_W-1:0] ts_out,
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
    output logic [3:0]      overflow,
    output logic            pol_out
`else
    output logic [3:0]      overflow
`endif
);

    typedef enum logic {EMPTY, FULL} state_e;

    localparam logic [2:0] SETTLE_DONE = 3'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
    logic [3:0]                  prev_q, prev_d;
    logic [2:0]                  settle_q, settle_d;
    logic [TS_W-1:0]             ts_q, ts_d;
    logic [3:0]                  pend_q, pend_d;
    logic [3:0][TS_W-1:0]        pts_q, pts_d;
    logic [3:0]                  ovf_q, ovf_d;
    logic [1:0]                  last_q, last_d;
    state_e                      state_q, state_d;
    logic [1:0]                  ch_q, ch_d;
    logic [TS_W-1:0]             tso_q, tso_d;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
    logic [3:0]                  ppol_q, ppol_d;
    logic                        polo_q, polo_d;
`endif

    logic [3:0] last_stage;
    logic [3:0] edge_det;
    logic [3:0] ovf_set;
    logic [3:0] gnt_vec;
    logic [1:0] gnt_idx;
    logic [1:0] cand;
    logic       found;
    logic       load;

    always_comb begin
        sync_d    = sync_q;
        pend_d    = pend_q;
        pts_d     = pts_q;
        last_d    = last_q;
        state_d   = state_q;
        ch_d      = ch_q;
        tso_d     = tso_q;
        ovf_set   = '0;
        found     = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
        ppol_d    = ppol_q;
        polo_d    = polo_q;
`endif

        sync_d[0] = ev_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        last_stage = sync_q[SYNC_STAGES-1];
        prev_d     = last_stage;

        // Edges are suppressed until the chain has been refilled from ev_in after
        // reset, so levels already high at release never look like a rise.
        settle_d = (settle_q == SETTLE_DONE) ? settle_q : settle_q + 3'd1;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
        edge_det = (settle_q == SETTLE_DONE) ? (last_stage ^ prev_q) : '0;
`else
        edge_det = (settle_q == SETTLE_DONE) ? (last_stage & ~prev_q) : '0;
`endif

        ts_d = ts_q + 1'b1;

        for (int unsigned i = 1; i <= 4; i++) begin
            cand = last_q + 2'(i);
            if (!found && pend_q[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end

        load    = found && ((state_q == EMPTY) || ready);
        gnt_vec = load ? (4'b0001 << gnt_idx) : 4'b0000;

        if (load) begin
            state_d         = FULL;
            ch_d            = gnt_idx;
            tso_d           = pts_q[gnt_idx];
            pend_d[gnt_idx] = 1'b0;
            last_d          = gnt_idx;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
            polo_d          = ppol_q[gnt_idx];
`endif
        end else if ((state_q == FULL) && ready) begin
            state_d = EMPTY;
        end

        // A channel granted this cycle frees its slot, so a coincident edge re-arms it.
        for (int unsigned c = 0; c < 4; c++) begin
            if (edge_det[c] && enable) begin
                if (pend_q[c] && !gnt_vec[c]) begin
                    ovf_set[c] = 1'b1;
                end else begin
                    pend_d[c] = 1'b1;
                    pts_d[c]  = ts_q;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
                    ppol_d[c] = last_stage[c];
`endif
                end
            end
        end

        ovf_d = (clr_ovf ? 4'b0000 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            settle_q <= '0;
            ts_q     <= '0;
            pend_q   <= '0;
            pts_q    <= '0;
            ovf_q    <= '0;
            last_q   <= 2'd3;
            state_q  <= EMPTY;
            ch_q     <= '0;
            tso_q    <= '0;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
            ppol_q   <= '0;
            polo_q   <= 1'b0;
`endif
        end else begin
            sync_q   <= sync_d;
            prev_q   <= prev_d;
            settle_q <= settle_d;
            ts_q     <= ts_d;
            pend_q   <= pend_d;
            pts_q    <= pts_d;
            ovf_q    <= ovf_d;
            last_q   <= last_d;
            state_q  <= state_d;
            ch_q     <= ch_d;
            tso_q    <= tso_d;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
            ppol_q   <= ppol_d;
            polo_q   <= polo_d;
`endif
        end
    end

    assign valid    = (state_q == FULL);
    assign ch_out   = ch_q;
    assign ts_out   = tso_q;
    assign overflow = ovf_q;
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
    assign pol_out  = polo_q;
`endif

endmodule

// File: tb/tb_event_arbiter.sv
// Scoreboard bench for event_arbiter: an event-level reference model queues
// expected records, a monitor pops them on each accepted output.
module tb_event_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned S = 3;

    typedef struct {
        logic [1:0]   ch;
        logic [W-1:0] ts;
        logic         pol;
    } rec_t;

    logic         clk = 1'b0;
    logic         rst_n, ena, rdy, clr;
    logic [3:0]   ev;
    logic         valid;
    logic [1:0]   ch_out;
    logic [W-1:0] ts_out;
    logic [3:0]   overflow;
    logic         pol_dut;

    int checks = 0;
    int errors = 0;

    event_arbiter #(.TS_W(W), .SYNC_STAGES(S)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ev_in    (ev),
        .enable   (ena),
        .ready    (rdy),
        .clr_ovf  (clr),
        .valid    (valid),
        .ch_out   (ch_out),
        .ts_out   (ts_out),
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
        .overflow (overflow),
        .pol_out  (pol_dut)
`else
        .overflow (overflow)
`endif
    );
`ifndef EVENT_ARBITER_BOTH_EDGES_EN
    assign pol_dut = 1'b1;
`endif

    always #5 clk = ~clk;

    // Reference model: event history per edge, pending slots, output slot.
    rec_t       exp_q[$];
    logic [3:0] samp[$];
    int         k;
    logic       m_pend[4];
    logic [W-1:0] m_pts[4];
    logic       m_ppol[4];
    logic [3:0] m_ovf;
    int         m_last;
    logic       m_valid;

    function automatic logic [3:0] sample_at(int j);
        if (j < 1 || j > samp.size()) return 4'b0000;
        return samp[j-1];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            samp.delete();
            k = 0;
            for (int c = 0; c < 4; c++) begin
                m_pend[c] = 1'b0; m_pts[c] = '0; m_ppol[c] = 1'b0;
            end
            m_ovf = 4'b0000; m_last = 3; m_valid = 1'b0;
        end else begin
            logic [W-1:0] ts_now;
            logic [3:0]   cur, prv;
            logic         det, pol;
            logic         pend_pre[4];
            int           g;
            ts_now = k[W-1:0];
            cur = sample_at(k - int'(S) + 1);
            prv = sample_at(k - int'(S));
            for (int c = 0; c < 4; c++) pend_pre[c] = m_pend[c];
            g = -1;
            if (!m_valid || rdy) begin
                for (int i = 1; i <= 4; i++) begin
                    if (g < 0 && m_pend[(m_last + i) % 4]) g = (m_last + i) % 4;
                end
            end
            if (g >= 0) begin
                rec_t r;
                r.ch = g[1:0]; r.ts = m_pts[g]; r.pol = m_ppol[g];
                exp_q.push_back(r);
                m_valid = 1'b1; m_pend[g] = 1'b0; m_last = g;
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (clr) m_ovf = 4'b0000;
            for (int c = 0; c < 4; c++) begin
`ifdef EVENT_ARBITER_BOTH_EDGES_EN
                det = (cur[c] != prv[c]);
                pol = cur[c];
`else
                det = cur[c] && !prv[c];
                pol = 1'b1;
`endif
                if (k <= int'(S)) det = 1'b0;
                if (det && ena) begin
                    if (pend_pre[c] && g != c) m_ovf[c] = 1'b1;
                    else begin
                        m_pend[c] = 1'b1; m_pts[c] = ts_now; m_ppol[c] = pol;
                    end
                end
            end
            samp.push_back(ev);
            k++;
        end
    end

    // Monitor: compare status every cycle and pop one record per accepted output.
    logic         hold_prev = 1'b0;
    logic [1:0]   held_ch;
    logic [W-1:0] held_ts;

    always begin
        @(negedge clk);
        #2;
        checks++;
        if (valid !== m_valid) begin
            errors++;
            $display("FAIL valid t=%0t got %b want %b", $time, valid, m_valid);
        end
        checks++;
        if (overflow !== m_ovf) begin
            errors++;
            $display("FAIL overflow t=%0t got %b want %b", $time, overflow, m_ovf);
        end
        if (hold_prev && valid) begin
            checks++;
            if (ch_out !== held_ch || ts_out !== held_ts) begin
                errors++;
                $display("FAIL hold t=%0t got ch%0d ts%0d want ch%0d ts%0d",
                         $time, ch_out, ts_out, held_ch, held_ts);
            end
        end
        if (rst_n && valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL record t=%0t got ch%0d ts%0d want none", $time, ch_out, ts_out);
            end else begin
                rec_t r;
                r = exp_q.pop_front();
                if (ch_out !== r.ch || ts_out !== r.ts || pol_dut !== r.pol) begin
                    errors++;
                    $display("FAIL record t=%0t got ch%0d ts%0d pol%b want ch%0d ts%0d pol%b",
                             $time, ch_out, ts_out, pol_dut, r.ch, r.ts, r.pol);
                end
            end
        end
        hold_prev = valid && !rdy && rst_n;
        held_ch   = ch_out;
        held_ts   = ts_out;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; ev = 4'b0000; ena = 1'b1; rdy = 1'b1; clr = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(10);

        ev = 4'b0100; cyc(8); ev = 4'b0000; cyc(8);
        ev = 4'b1111; cyc(10); ev = 4'b0000; cyc(10);

        rdy = 1'b0;
        ev = 4'b0010; cyc(6); ev = 4'b0000; cyc(6);
        ev = 4'b0010; cyc(6); ev = 4'b0000; cyc(6);
        ev = 4'b0010; cyc(6); ev = 4'b0000; cyc(6);
        checks++;
        if (overflow !== 4'b0010) begin
            errors++;
            $display("FAIL ovf_direct got %b want 0010", overflow);
        end
        clr = 1'b1; cyc(1); clr = 1'b0;
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear got %b want 0000", overflow);
        end
        rdy = 1'b1; cyc(10);

        ena = 1'b0; ev = 4'b1001; cyc(8); ev = 4'b0000; cyc(4); ena = 1'b1;
        cyc(4);

        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(5) == 0) ev[c] = ~ev[c];
            end
            rdy = ($urandom_range(3) != 0);
            ena = ($urandom_range(15) != 0);
            clr = ($urandom_range(31) == 0);
            cyc(1);
        end

        ev = 4'b0000; rdy = 1'b1; ena = 1'b1; clr = 1'b0; cyc(12);
        rdy = 1'b0; ev = 4'b0001; cyc(8);
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL full_before_reset got %b want 1", valid);
        end
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        checks++;
        if (valid !== 1'b0 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL reset_drop got v%b ovf%b want v0 ovf0000", valid, overflow);
        end
        rdy = 1'b1; cyc(30);

        ev = 4'b0000; cyc(20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending records want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
